// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares one SDRAM controller between two bus masters. Port 0 is the CPU
//   bus, port 1 a secondary master (DMA, video fetch). Level-held requests
//   are serialised into single 32-bit controller transactions, and each
//   requester gets a one-cycle ack carrying read data (or an error flag when
//   the controller never started the transaction).
//
// Parameters
//   ROUND_ROBIN   1: alternate grants on contention, 0: port 0 always wins
//   BUSY_TIMEOUT  cycles to wait for mem_busy after the issue strobe (>= 2)
//   TO_WIDTH      width of the timeout counter
//
// Ports
//   clk, resetn                    clock shared with the controller, async active-low reset
//   pN_req/addr/wdata/wmask        requester side, held until pN_ack (wmask 0 = read)
//   pN_ack/rdata/err               one-cycle completion, read data, timeout flag
//   mem_addr/din/wmask/valid       controller request, valid is a one-cycle strobe
//   mem_dout/busy/initialized      controller read data, activity, init complete
module sdram_arbiter #(
  parameter int ROUND_ROBIN  = 1,
  parameter int BUSY_TIMEOUT = 64,
  parameter int TO_WIDTH     = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        p0_req,
  input  logic [24:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wmask,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic [24:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wmask,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [24:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_wmask,
  output logic        mem_valid,
  input  logic [31:0] mem_dout,
  input  logic        mem_busy,
  input  logic        mem_initialized
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESPOND
  } state_t;

  localparam logic [TO_WIDTH-1:0] TO_ONE  = TO_WIDTH'(1);
  localparam logic [TO_WIDTH-1:0] TO_LOAD = TO_WIDTH'(BUSY_TIMEOUT);

  state_t              state;
  logic                grant;       // port owning the current transaction
  logic                last_grant;  // port granted most recently
  logic [TO_WIDTH-1:0] to_cnt;

  logic any_req;
  logic winner;

  // Winner selection: a lone requester always wins; on contention either
  // alternate away from the last grant or give port 0 fixed priority.
  always_comb begin
    any_req = p0_req | p1_req;
    if (p0_req && p1_req) begin
      winner = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
    end else begin
      winner = ~p0_req;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;  // port 0 wins the first contention
      to_cnt     <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_wmask  <= '0;
      mem_valid  <= 1'b0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_err     <= 1'b0;
      p1_err     <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Holding off while the controller is busy keeps mem_valid from
          // ever overlapping an in-flight transaction.
          if (mem_initialized && !mem_busy && any_req) begin
            grant      <= winner;
            last_grant <= winner;
            mem_addr   <= winner ? p1_addr  : p0_addr;
            mem_din    <= winner ? p1_wdata : p0_wdata;
            mem_wmask  <= winner ? p1_wmask : p0_wmask;
            mem_valid  <= 1'b1;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          mem_valid <= 1'b0;
          to_cnt    <= TO_LOAD;
          state     <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (mem_busy) begin
            state <= WAIT_DONE;
          end else if (to_cnt == '0) begin
            // Controller never picked the request up: answer with an error.
            p0_ack <= ~grant;
            p1_ack <= grant;
            p0_err <= ~grant;
            p1_err <= grant;
            state  <= RESPOND;
          end else begin
            to_cnt <= to_cnt - TO_ONE;
          end
        end

        WAIT_DONE: begin
          if (!mem_busy) begin
            if (grant) begin
              p1_rdata <= mem_dout;
            end else begin
              p0_rdata <= mem_dout;
            end
            p0_ack <= ~grant;
            p1_ack <= grant;
            state  <= RESPOND;
          end
        end

        RESPOND: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          p0_err <= 1'b0;
          p1_err <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Directed bench for sdram_arbiter. Instance 0 uses round-robin
//   arbitration, instance 1 fixed priority; both share requester data and
//   each sees its own small controller model (busy for busy_len cycles after
//   mem_valid, then presents model_dout).
module tb_sdram_arbiter;

  localparam int BT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        mem_initialized;
  logic        p0_req [2];
  logic        p1_req [2];
  logic [24:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic [3:0]  p0_wmask, p1_wmask;
  logic        p0_ack [2];
  logic        p1_ack [2];
  logic        p0_err [2];
  logic        p1_err [2];
  logic [31:0] p0_rdata [2];
  logic [31:0] p1_rdata [2];
  logic [24:0] mem_addr [2];
  logic [31:0] mem_din [2];
  logic [3:0]  mem_wmask [2];
  logic        mem_valid [2];
  logic [31:0] mem_dout [2];
  logic        mem_busy [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    sdram_arbiter #(
      .ROUND_ROBIN  (gi == 0 ? 1 : 0),
      .BUSY_TIMEOUT (BT)
    ) u_dut (
      .clk             (clk),
      .resetn          (resetn),
      .p0_req          (p0_req[gi]),
      .p0_addr         (p0_addr),
      .p0_wdata        (p0_wdata),
      .p0_wmask        (p0_wmask),
      .p0_ack          (p0_ack[gi]),
      .p0_rdata        (p0_rdata[gi]),
      .p0_err          (p0_err[gi]),
      .p1_req          (p1_req[gi]),
      .p1_addr         (p1_addr),
      .p1_wdata        (p1_wdata),
      .p1_wmask        (p1_wmask),
      .p1_ack          (p1_ack[gi]),
      .p1_rdata        (p1_rdata[gi]),
      .p1_err          (p1_err[gi]),
      .mem_addr        (mem_addr[gi]),
      .mem_din         (mem_din[gi]),
      .mem_wmask       (mem_wmask[gi]),
      .mem_valid       (mem_valid[gi]),
      .mem_dout        (mem_dout[gi]),
      .mem_busy        (mem_busy[gi]),
      .mem_initialized (mem_initialized)
    );
  end

  // Controller model settings, driven by the stimulus process only.
  int          busy_len;
  bit          never_busy;
  logic [31:0] model_dout;

  int bcnt [2];
  always @(posedge clk or negedge resetn) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        mem_busy[k] <= 1'b0;
        bcnt[k]     <= 0;
        mem_dout[k] <= '0;
      end else if (mem_valid[k] && !never_busy) begin
        mem_busy[k] <= 1'b1;
        bcnt[k]     <= busy_len - 1;
        mem_dout[k] <= '0;
      end else if (mem_busy[k]) begin
        if (bcnt[k] == 0) begin
          mem_busy[k] <= 1'b0;
          mem_dout[k] <= model_dout;
        end else begin
          bcnt[k] <= bcnt[k] - 1;
        end
      end
    end
  end

  // Bus monitor: counts strobes and acks, logs grant order, measures the
  // gap between an ack and the next issue strobe.
  int          cyc_n = 0;
  int          nvalid [2]   = '{0, 0};
  int          nack0 [2]    = '{0, 0};
  int          nack1 [2]    = '{0, 0};
  int          nlog [2]     = '{0, 0};
  int          viol [2]     = '{0, 0};
  int          gap [2]      = '{0, 0};
  int          last_ack [2] = '{0, 0};
  logic        alog [2][64];
  logic [24:0] va_addr [2];
  logic [31:0] va_din [2];
  logic [3:0]  va_wmask [2];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_valid[k] === 1'b1) begin
        nvalid[k]   <= nvalid[k] + 1;
        va_addr[k]  <= mem_addr[k];
        va_din[k]   <= mem_din[k];
        va_wmask[k] <= mem_wmask[k];
        gap[k]      <= cyc_n - last_ack[k];
        if (mem_busy[k] || !mem_initialized) viol[k] <= viol[k] + 1;
      end
      if (p0_ack[k] === 1'b1 || p1_ack[k] === 1'b1) begin
        last_ack[k]              <= cyc_n;
        alog[k][6'(nlog[k])]     <= p1_ack[k];
        nlog[k]                  <= nlog[k] + 1;
      end
      if (p0_ack[k] === 1'b1) nack0[k] <= nack0[k] + 1;
      if (p1_ack[k] === 1'b1) nack1[k] <= nack1[k] + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step to just after the falling edge: outputs are settled and monitor
  // updates from that edge are visible.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) for the ack of a port, then release its request.
  task automatic wait_ack(input int k, input bit port, input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      cyc();
      if ((port ? p1_ack[k] : p0_ack[k]) === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (port) p1_req[k] = 1'b0;
    else      p0_req[k] = 1'b0;
    $display("txn inst%0d port%0d: ack after %0d cycles, rdata=%h err=%b", k, port, lat,
             port ? p1_rdata[k] : p0_rdata[k], port ? p1_err[k] : p0_err[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, t, a0, a1, bv, base;

    resetn          = 1'b0;
    mem_initialized = 1'b0;
    for (int k = 0; k < 2; k++) begin
      p0_req[k] = 1'b0;
      p1_req[k] = 1'b0;
    end
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    p0_wmask = '0; p1_wmask = '0;
    busy_len = 8; never_busy = 1'b0; model_dout = '0;

    repeat (3) cyc();
    for (int k = 0; k < 2; k++) begin
      chk("rst_flags", 64'({p0_ack[k], p1_ack[k], p0_err[k], p1_err[k], mem_valid[k]}), 64'(0));
      chk("rst_mem", 64'({mem_addr[k], mem_din[k], mem_wmask[k]}), 64'(0));
      chk("rst_rdata", {p0_rdata[k], p1_rdata[k]}, 64'(0));
    end
    resetn = 1'b1;
    cyc();
    mem_initialized = 1'b1;

    // Single read on port 0.
    p0_addr = 25'h0000100; p0_wdata = 32'h11111111; p0_wmask = 4'h0;
    model_dout = 32'hDEADBEEF;
    bv = nvalid[0]; a0 = nack0[0]; a1 = nack1[0];
    p0_req[0] = 1'b1;
    wait_ack(0, 1'b0, 40, lat);
    chk("rd_latency", 64'(lat), 64'(11));
    chk("rd_rdata", 64'(p0_rdata[0]), 64'(32'hDEADBEEF));
    chk("rd_err", 64'(p0_err[0]), 64'(0));
    chk("rd_addr", 64'(va_addr[0]), 64'(25'h0000100));
    chk("rd_wmask", 64'(va_wmask[0]), 64'(0));
    cyc(); cyc();
    chk("rd_nvalid", 64'(nvalid[0] - bv), 64'(1));
    chk("rd_nack0", 64'(nack0[0] - a0), 64'(1));
    chk("rd_nack1", 64'(nack1[0] - a1), 64'(0));

    // Write on port 1 at the top of the address space.
    p1_addr = 25'h1FFFFFC; p1_wdata = 32'hA5A55A5A; p1_wmask = 4'hC;
    model_dout = 32'h0BADF00D;
    bv = nvalid[0]; a0 = nack0[0]; a1 = nack1[0];
    p1_req[0] = 1'b1;
    wait_ack(0, 1'b1, 40, lat);
    chk("wr_latency", 64'(lat), 64'(11));
    chk("wr_addr", 64'(va_addr[0]), 64'(25'h1FFFFFC));
    chk("wr_din", 64'(va_din[0]), 64'(32'hA5A55A5A));
    chk("wr_wmask", 64'(va_wmask[0]), 64'(4'hC));
    chk("wr_p1_rdata", 64'(p1_rdata[0]), 64'(32'h0BADF00D));
    chk("wr_p0_rdata_hold", 64'(p0_rdata[0]), 64'(32'hDEADBEEF));
    cyc(); cyc();
    chk("wr_nvalid", 64'(nvalid[0] - bv), 64'(1));
    chk("wr_nack1", 64'(nack1[0] - a1), 64'(1));
    chk("wr_nack0", 64'(nack0[0] - a0), 64'(0));

    // Round-robin contention: four transactions, both requests held.
    p1_wmask = 4'h0;
    base = nlog[0];
    p0_req[0] = 1'b1; p1_req[0] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (nlog[0] - base >= 4) break;
    end
    p0_req[0] = 1'b0; p1_req[0] = 1'b0;
    $display("txn inst0 contention: %0d grants logged", nlog[0] - base);
    repeat (20) cyc();
    chk("rr_count", 64'(nlog[0] - base), 64'(4));
    chk("rr_order", 64'({alog[0][6'(base)], alog[0][6'(base + 1)],
                         alog[0][6'(base + 2)], alog[0][6'(base + 3)]}), 64'(4'b0101));
    chk("rr_idle_gap", 64'(gap[0]), 64'(2));

    // Fixed-priority contention on instance 1: p0 leaves after three acks.
    base = nlog[1]; a0 = nack0[1];
    p0_req[1] = 1'b1; p1_req[1] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (p0_ack[1] === 1'b1 && nack0[1] - a0 == 3) p0_req[1] = 1'b0;
      if (p1_ack[1] === 1'b1) break;
    end
    p0_req[1] = 1'b0; p1_req[1] = 1'b0;
    $display("txn inst1 contention: %0d grants logged", nlog[1] - base);
    cyc(); cyc();
    chk("fp_count", 64'(nlog[1] - base), 64'(4));
    chk("fp_order", 64'({alog[1][6'(base)], alog[1][6'(base + 1)],
                         alog[1][6'(base + 2)], alog[1][6'(base + 3)]}), 64'(4'b0001));

    // Initialisation gating.
    mem_initialized = 1'b0;
    bv = nvalid[0];
    p0_req[0] = 1'b1;
    repeat (100) cyc();
    chk("init_gate", 64'(nvalid[0] - bv), 64'(0));
    mem_initialized = 1'b1;
    n = 1;
    while (mem_valid[0] !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    chk("init_issue_cycle", 64'(n), 64'(2));
    wait_ack(0, 1'b0, 40, lat);
    chk("init_latency", 64'(lat), 64'(10));

    // Timeout: controller never goes busy.
    cyc();
    never_busy = 1'b1;
    p0_req[0] = 1'b1;
    n = 0;
    while (mem_valid[0] !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    chk("to_valid_seen", 64'(mem_valid[0]), 64'(1));
    t = 0;
    while (p0_ack[0] !== 1'b1 && t < 100) begin
      cyc();
      t++;
    end
    p0_req[0] = 1'b0;
    $display("txn inst0 port0 timeout: ack %0d cycles after valid, err=%b", t, p0_err[0]);
    chk("to_delay", 64'(t), 64'(BT + 2));
    chk("to_err", 64'(p0_err[0]), 64'(1));
    cyc();
    chk("to_clear", 64'({p0_ack[0], p0_err[0]}), 64'(0));
    never_busy = 1'b0;

    // Reset during WAIT_DONE.
    cyc();
    busy_len = 20;
    p0_addr = 25'h0ABCDEF; p0_wdata = 32'hCAFEF00D; p0_wmask = 4'hF;
    a0 = nack0[0]; a1 = nack1[0];
    p0_req[0] = 1'b1;
    n = 0;
    while (mem_busy[0] !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    cyc(); cyc();
    chk("rst_mid_busy", 64'(mem_busy[0]), 64'(1));
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_flags", 64'({p0_ack[0], p1_ack[0], p0_err[0], p1_err[0], mem_valid[0]}), 64'(0));
    chk("rst_mid_mem", 64'({mem_addr[0], mem_din[0], mem_wmask[0]}), 64'(0));
    chk("rst_mid_rdata", {p0_rdata[0], p1_rdata[0]}, 64'(0));
    p0_req[0] = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;
    repeat (30) cyc();
    $display("txn inst0 port0 reset mid-transfer: %0d acks afterwards", (nack0[0] - a0) + (nack1[0] - a1));
    chk("rst_no_ack", 64'((nack0[0] - a0) + (nack1[0] - a1)), 64'(0));

    chk("valid_while_busy", 64'(viol[0] + viol[1]), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
